// File: rtl/iocfg_pkg.sv
// Shared constants, TSMUX encodings and FSM state type for the IO configuration loader.
// Optional readback logic elsewhere is enabled with `define IOCFG_READBACK_EN.
package iocfg_pkg;

   localparam int unsigned CFG_BITS = 3;

   // TSMUX field values; 2'b11 also drives and is passed through unchanged.
   localparam logic [1:0] TS_OFF  = 2'b00;
   localparam logic [1:0] TS_CTRL = 2'b01;
   localparam logic [1:0] TS_ON   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_LATCH,
      ST_DONE
   } iocfg_state_t;

   function automatic logic [CFG_BITS-1:0] cfg_word(input logic [1:0] tsmux, input logic dorreg);
      return {tsmux, dorreg};
   endfunction

endpackage

// File: rtl/iocfg_shifter.sv
// 3-bit parallel-load, MSB-first shifter with bit counter and last-bit flag.
// With `define IOCFG_READBACK_EN it also captures the chain tail into RB data.
module iocfg_shifter
   import iocfg_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_load,
   input  logic                i_shift,
   input  logic [CFG_BITS-1:0] i_data,
   output logic                o_sdo,
   output logic                o_last
`ifdef IOCFG_READBACK_EN
   ,
   input  logic                i_sdi,
   output logic [CFG_BITS-1:0] o_rb_data,
   output logic                o_rb_valid
`endif
);

   logic [CFG_BITS-1:0] r_word;
   logic [1:0]          r_bit_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word    <= '0;
         r_bit_cnt <= '0;
      end else if (i_load) begin
         r_word    <= i_data;
         r_bit_cnt <= 2'(CFG_BITS - 1);
      end else if (i_shift) begin
         r_word <= {r_word[CFG_BITS-2:0], 1'b0};
         if (r_bit_cnt != '0) begin
            r_bit_cnt <= r_bit_cnt - 2'd1;
         end
      end
   end

   // The MSB of the shifting word is word[bit_cnt] of the originally loaded value.
   assign o_sdo  = r_word[CFG_BITS-1];
   assign o_last = (r_bit_cnt == '0);

`ifdef IOCFG_READBACK_EN
   logic [CFG_BITS-2:0] r_cap;
   logic [CFG_BITS-1:0] r_rb_data;
   logic                r_rb_valid;

   // The first two tail bits are held in r_cap; the third completes the word directly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cap      <= '0;
         r_rb_data  <= '0;
         r_rb_valid <= 1'b0;
      end else begin
         r_rb_valid <= i_shift & o_last;
         if (i_shift) begin
            if (o_last) begin
               r_rb_data <= {r_cap, i_sdi};
            end else begin
               r_cap <= {r_cap[CFG_BITS-3:0], i_sdi};
            end
         end
      end
   end

   assign o_rb_data  = r_rb_data;
   assign o_rb_valid = r_rb_valid;
`endif

endmodule

// File: rtl/iocfg_loader.sv
// Serial configuration writer for a daisy-chained bank of ioblock pad cells.
// Define IOCFG_READBACK_EN to add SDI/RB_DATA/RB_VALID readback of displaced words.
module iocfg_loader
   import iocfg_pkg::*;
#(
   parameter int unsigned NUM_IO = 8
)
(
   input  logic                IOCLK,
   input  logic                RST_N,
   input  logic                START,
   input  logic                CFG_VALID,
   input  logic [CFG_BITS-1:0] CFG_DATA,
   output logic                CFG_READY,
   output logic                BUSY,
   output logic                SCLK_EN,
   output logic                SDO,
   output logic                LATCH,
   output logic                DONE
`ifdef IOCFG_READBACK_EN
   ,
   input  logic                SDI,
   output logic [CFG_BITS-1:0] RB_DATA,
   output logic                RB_VALID
`endif
);

   localparam int unsigned     IO_W    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
   localparam logic [IO_W-1:0] IO_LAST = IO_W'(NUM_IO - 1);

   iocfg_state_t    r_state;
   logic [IO_W-1:0] r_io_cnt;
   logic            r_cfg_ready;
   logic            r_busy;
   logic            r_sclk_en;
   logic            r_latch;
   logic            r_done;

   logic            w_load;
   logic            w_sdo;
   logic            w_last;

   assign w_load = r_cfg_ready & CFG_VALID;

   iocfg_shifter u_shifter (
      .i_clk      (IOCLK),
      .i_rst_n    (RST_N),
      .i_load     (w_load),
      .i_shift    (r_sclk_en),
      .i_data     (CFG_DATA),
      .o_sdo      (w_sdo),
      .o_last     (w_last)
`ifdef IOCFG_READBACK_EN
      ,
      .i_sdi      (SDI),
      .o_rb_data  (RB_DATA),
      .o_rb_valid (RB_VALID)
`endif
   );

   // Output flags are registered alongside each state transition so they track r_state exactly.
   always_ff @(posedge IOCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_io_cnt    <= '0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_sclk_en   <= 1'b0;
         r_latch     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_state     <= ST_LOAD;
                  r_io_cnt    <= '0;
                  r_cfg_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (CFG_VALID) begin
                  r_state     <= ST_SHIFT;
                  r_cfg_ready <= 1'b0;
                  r_sclk_en   <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_last) begin
                  r_sclk_en <= 1'b0;
                  if (r_io_cnt == IO_LAST) begin
                     r_state <= ST_LATCH;
                     r_latch <= 1'b1;
                  end else begin
                     r_state     <= ST_LOAD;
                     r_io_cnt    <= r_io_cnt + IO_W'(1);
                     r_cfg_ready <= 1'b1;
                  end
               end
            end
            ST_LATCH: begin
               r_state <= ST_DONE;
               r_latch <= 1'b0;
               r_done  <= 1'b1;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_io_cnt    <= '0;
               r_cfg_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_sclk_en   <= 1'b0;
               r_latch     <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign CFG_READY = r_cfg_ready;
   assign BUSY      = r_busy;
   assign SCLK_EN   = r_sclk_en;
   assign SDO       = r_sclk_en & w_sdo;
   assign LATCH     = r_latch;
   assign DONE      = r_done;

endmodule

// File: tb/tb_iocfg_loader.sv
// Scoreboard bench for iocfg_loader with a behavioural model of the ioblock chain.
// Readback checks are compiled in when IOCFG_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_iocfg_loader;
   import iocfg_pkg::*;

   localparam int unsigned N     = 8;
   localparam int unsigned NB    = CFG_BITS * N;
   localparam int          STALL = 5;
   localparam int          NONE  = 1000;

   localparam int K_SDO   = 0;
   localparam int K_LATCH = 1;
   localparam int K_DONE  = 2;
   localparam int K_IDLE  = 3;
   localparam int K_RB    = 4;

   logic       IOCLK     = 1'b0;
   logic       RST_N     = 1'b0;
   logic       START     = 1'b0;
   logic       CFG_VALID = 1'b0;
   logic [2:0] CFG_DATA  = 3'b000;
   logic       CFG_READY, BUSY, SCLK_EN, SDO, LATCH, DONE;
`ifdef IOCFG_READBACK_EN
   logic       SDI;
   logic [2:0] RB_DATA;
   logic       RB_VALID;
`endif

   iocfg_loader #(.NUM_IO(N)) dut (
      .IOCLK     (IOCLK),
      .RST_N     (RST_N),
      .START     (START),
      .CFG_VALID (CFG_VALID),
      .CFG_DATA  (CFG_DATA),
      .CFG_READY (CFG_READY),
      .BUSY      (BUSY),
      .SCLK_EN   (SCLK_EN),
      .SDO       (SDO),
      .LATCH     (LATCH),
      .DONE      (DONE)
`ifdef IOCFG_READBACK_EN
      ,
      .SDI       (SDI),
      .RB_DATA   (RB_DATA),
      .RB_VALID  (RB_VALID)
`endif
   );

   always #5 IOCLK = ~IOCLK;

   typedef struct {
      int         kind;
      logic [2:0] val;
      int         cyc;
   } ev_t;

   ev_t q_sdo[$];
   ev_t q_ctl[$];
   ev_t q_rb[$];

   int n_tests   = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int start_ref = 0;

   logic [2:0] words[N];

   always @(posedge IOCLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Chain model: stage 0 takes SDO, the tail feeds SDI; LATCH copies stages into live config.
   logic [NB-1:0] chain_m = '0;
   logic [NB-1:0] live_m  = '0;
   logic          preload = 1'b0;

   always @(posedge IOCLK) begin
      if (preload) chain_m <= {N{3'b110}};
      else if (SCLK_EN) chain_m <= {chain_m[NB-2:0], SDO};
      if (LATCH) live_m <= chain_m;
   end

`ifdef IOCFG_READBACK_EN
   assign SDI = chain_m[NB-1];
`endif

   task automatic ctl_event(input int kind, input int rel);
      ev_t e;
      if (q_ctl.size() == 0) begin
         check("ctl_unexpected_kind", kind, -1);
      end else begin
         e = q_ctl.pop_front();
         check("ctl_kind", kind, e.kind);
         check("ctl_cycle", rel, e.cyc);
      end
   endtask

   logic prev_busy = 1'b0;

   always @(negedge IOCLK) begin
      int  rel;
      ev_t e;
      rel = cyc - start_ref + 1;
      if (SCLK_EN) begin
         if (q_sdo.size() == 0) begin
            check("sdo_unexpected_shift", 1, 0);
         end else begin
            e = q_sdo.pop_front();
            check("sdo_bit", int'(SDO), int'(e.val));
            check("sdo_cycle", rel, e.cyc);
         end
      end
      if (LATCH) ctl_event(K_LATCH, rel);
      if (DONE) ctl_event(K_DONE, rel);
      if (prev_busy && !BUSY) ctl_event(K_IDLE, rel);
      prev_busy = BUSY;
`ifdef IOCFG_READBACK_EN
      if (RB_VALID) begin
         if (q_rb.size() == 0) begin
            check("rb_unexpected_pulse", 1, 0);
         end else begin
            e = q_rb.pop_front();
            check("rb_data", int'(RB_DATA), int'(e.val));
            check("rb_cycle", rel, e.cyc);
         end
      end
`endif
   end

   task automatic outputs_zero(input string tag);
      check({tag, "_cfg_ready"}, int'(CFG_READY), 0);
      check({tag, "_busy"}, int'(BUSY), 0);
      check({tag, "_sclk_en"}, int'(SCLK_EN), 0);
      check({tag, "_sdo"}, int'(SDO), 0);
      check({tag, "_latch"}, int'(LATCH), 0);
      check({tag, "_done"}, int'(DONE), 0);
`ifdef IOCFG_READBACK_EN
      check({tag, "_rb_data"}, int'(RB_DATA), 0);
      check({tag, "_rb_valid"}, int'(RB_VALID), 0);
`endif
   endtask

   task automatic host(input int stall_at);
      logic r;
      int   guard;
      for (int k = 0; k < int'(N) && RST_N; k++) begin
         if (k == stall_at) begin
            CFG_VALID = 1'b0;
            r = 1'b0;
            guard = 0;
            while (!r && RST_N && guard < 50) begin
               @(negedge IOCLK);
               r = CFG_READY;
               guard++;
            end
            repeat (STALL) @(posedge IOCLK);
            #2;
         end
         CFG_VALID = 1'b1;
         CFG_DATA  = words[k];
         r = 1'b0;
         guard = 0;
         while (!r && RST_N && guard < 50) begin
            @(negedge IOCLK);
            r = CFG_READY;
            @(posedge IOCLK);
            #2;
            guard++;
         end
         if (!r && RST_N) check("host_accept_timeout", 0, 1);
      end
      CFG_VALID = 1'b0;
   endtask

   task automatic run_frame(input int stall_at, input int abort_at, input int busy_start_at);
      int            acc;
      int            s;
      int            endc;
      int            guard;
      logic          bitv;
      logic [NB-1:0] snap;
      logic [NB-1:0] live_before;
      logic [NB-1:0] live_exp;
      snap        = chain_m;
      live_before = live_m;
      s           = 0;
      for (int k = 0; k < int'(N); k++) begin
         if (k == stall_at) s += STALL;
         acc = 1 + 4 * k + s;
         for (int b = 0; b < 3; b++) begin
            bitv = words[k][2-b];
            if (acc + 1 + b < abort_at) q_sdo.push_back('{K_SDO, {2'b00, bitv}, acc + 1 + b});
         end
         if (acc + 4 < abort_at) q_rb.push_back('{K_RB, snap[3*(int'(N)-1-k) +: 3], acc + 4});
      end
      endc = 1 + 4 * int'(N) + s;
      if (endc < abort_at) begin
         q_ctl.push_back('{K_LATCH, 3'b000, endc});
         q_ctl.push_back('{K_DONE, 3'b000, endc + 1});
         q_ctl.push_back('{K_IDLE, 3'b000, endc + 2});
      end else begin
         q_ctl.push_back('{K_IDLE, 3'b000, abort_at});
      end

      @(posedge IOCLK);
      #2 START = 1'b1;
      @(posedge IOCLK);
      #2 START = 1'b0;
      start_ref = cyc;

      fork
         host(stall_at);
         begin
            if (abort_at != NONE) begin
               repeat (abort_at - 1) @(posedge IOCLK);
               #2 RST_N = 1'b0;
               @(negedge IOCLK);
               outputs_zero("abort");
               repeat (3) @(posedge IOCLK);
               #2 RST_N = 1'b1;
            end
         end
         begin
            if (busy_start_at != NONE) begin
               repeat (busy_start_at - 1) @(posedge IOCLK);
               #2 START = 1'b1;
               @(posedge IOCLK);
               #2 START = 1'b0;
            end
         end
      join

      guard = 0;
      while ((BUSY || q_ctl.size() != 0) && guard < 100) begin
         @(posedge IOCLK);
         #3;
         guard++;
      end
      if (guard >= 100) check("frame_end_timeout", guard, 0);
      check("sdo_left_over", q_sdo.size(), 0);
      check("ctl_left_over", q_ctl.size(), 0);
`ifdef IOCFG_READBACK_EN
      check("rb_left_over", q_rb.size(), 0);
`else
      q_rb.delete();
`endif

      if (abort_at != NONE) begin
         live_exp = live_before;
      end else begin
         for (int i = 0; i < int'(N); i++) live_exp[3*i +: 3] = words[int'(N)-1-i];
      end
      for (int i = 0; i < int'(N); i++) check($sformatf("live_io%0d", i), int'(live_m[3*i +: 3]), int'(live_exp[3*i +: 3]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      repeat (3) @(posedge IOCLK);
      @(negedge IOCLK);
      outputs_zero("reset");
      @(posedge IOCLK);
      #2 RST_N = 1'b1;

      sc = 0;
      repeat (10) begin
         @(negedge IOCLK);
         sc += int'(SCLK_EN) + int'(BUSY);
      end
      check("idle_activity", sc, 0);

      // Back-to-back frame with a START pulse in cycle 10 that must be ignored.
      words = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b011, 3'b100, 3'b001, 3'b110};
      run_frame(NONE, NONE, 10);

      // Host stall of 5 cycles before word 3.
      words = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b110, 3'b100, 3'b010, 3'b000};
      run_frame(3, NONE, NONE);

      // Reset in cycle 20: no LATCH, live configuration unchanged.
      words = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
      run_frame(NONE, 20, NONE);

      // Preload chain with 3'b110 per IO and load every TSMUX encoding.
      @(posedge IOCLK);
      #2 preload = 1'b1;
      @(posedge IOCLK);
      #2 preload = 1'b0;
      words = '{cfg_word(TS_OFF, 1'b1), cfg_word(TS_CTRL, 1'b0), cfg_word(TS_ON, 1'b1), cfg_word(2'b11, 1'b0),
                cfg_word(TS_OFF, 1'b0), cfg_word(TS_CTRL, 1'b1), cfg_word(TS_ON, 1'b0), cfg_word(2'b11, 1'b1)};
      run_frame(NONE, NONE, NONE);

      repeat (3) @(posedge IOCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
